regfile_port_arbiter: RTL and testbench
=======================================

# regfile_port_arbiter

Sits between the decode/operand-fetch stage and the write-back stage on one side and the single-ported 32×32 register file on the other. It buffers write-backs in a small searchable FIFO and arbitrates the one register-file index port between operand reads and queued writes each cycle. It forwards data from pending writes to reads, so the pipeline never sees a stale register.

## Interface
Parameters:
- DEPTH, 4: write-back FIFO entries (power of two, ≥2)
- DATA_W, 32: register width
- IDX_W, 5: register index width

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- rdReq  in  1  decode requests an operand read this cycle
- rdIndex  in  IDX_W  register to read
- rdReady  out  1  read accepted this cycle (combinational)
- rdValid  out  1  read data valid; registered, one cycle after acceptance
- rdData  out  DATA_W  read result, meaningful only while rdValid=1
- wbValid  in  1  write-back stage presents a result
- wbIndex  in  IDX_W  destination register
- wbData  in  DATA_W  result value
- wbReady  out  1  FIFO can accept (= !full)
- rfIndex  out  IDX_W  to register-file index port
- rfValueInput  out  DATA_W  to register-file write data
- rfReadEnable  out  1  register-file read strobe
- rfWriteEnable  out  1  register-file write strobe
- rfValueOutput  in  DATA_W  register-file read data; valid the cycle after rfReadEnable
- pendingCount  out  $clog2(DEPTH)+1  occupied FIFO entries

## Operation
- Write-back: the arbiter enqueues on wbValid && wbReady. A write with wbIndex=0 is accepted and dropped; it is never enqueued.
- Read source, evaluated in the cycle a read is accepted, in priority order:
  - index 0 returns 0;
  - otherwise, the youngest FIFO entry whose index matches returns its data (forwarding), with no register-file access;
  - otherwise, the arbiter issues a register-file read.
- The FIFO search covers only entries stored before the current edge. A write enqueued in the same cycle is not visible to a read in that cycle.
- Port arbitration each cycle:
  - FIFO full: drain the head entry as a write; rdReady=0.
  - Else rdReq and a register-file read is needed: issue the read; rdReady=1; no write.
  - Else rdReq served by index 0 or forwarding: rdReady=1. The head entry (if any) drains as a write in the same cycle, because the port is free.
  - Else FIFO non-empty: drain the head entry.
  - Else idle: all rf* enables are 0.
- Drain writes the head entry's index and data, asserts rfWriteEnable, and pops the entry at the edge.
- rfReadEnable and rfWriteEnable are never both 1.
- Forwarding stays correct while the matching entry is draining in the same cycle, because the comparison uses pre-edge contents.

## Timing
- rf* outputs and rdReady are combinational from FIFO state and inputs.
- Read latency is 1 cycle: a read accepted in cycle N gives rdValid=1 in N+1.
  - rdData in N+1 is rfValueOutput for a register-file read, or a value registered at edge N for index 0 or forwarding.
- A single-cycle read latency holds for every source. One read can be accepted per cycle.
- Write to architectural visibility: enqueue at edge N; the entry becomes visible through forwarding from cycle N+1, and in the register file no later than after DEPTH further drain opportunities.
- Simultaneous enqueue and drain in the same cycle is allowed: the count is unchanged and head and tail pointers both advance.
- Pointers wrap modulo DEPTH; full/empty are decided by count, not by pointer equality.
- Reset values:
  - FIFO empty, pendingCount=0, wbReady=1.
  - rdValid=0 and rdData=0.
  - With no requests, all rf* enables are 0.
- Reset asserted mid-operation: FIFO contents are discarded (not written) and any in-flight rdValid is cancelled.

## Structure
- A shared package regfile_pkg holds IDX_W, DATA_W, NUM_REGS=32, and the arbitration-decision enum ARB_IDLE, ARB_READ, ARB_DRAIN, ARB_FWD_DRAIN.
- One sub-module, wb_fifo, owns the circular buffer and the youngest-match search (matchHit, matchData). regfile_port_arbiter holds the arbitration logic, the read-source mux, and the rdValid/rdData registers.

## Test plan
- Write then read: write r5=0xDEADBEEF, idle until pendingCount=0, read r5 → rfReadEnable in the accept cycle; rdValid=1, rdData=0xDEADBEEF next cycle.
- Forwarding: write r7=0x11, next cycle write r7=0x22, next cycle read r7 → no rfReadEnable; rdData=0x22 one cycle later.
- r0 behaviour: write r0=0xFFFFFFFF (pendingCount stays 0), read r0 → rdData=0.
- Full FIFO: enqueue 4 writes while rdReq is held high every cycle → wbReady=0 and rdReady=0 while full; the drain cycle asserts rfWriteEnable; the read is accepted once count<4, and all 4 entries eventually reach the register file in order.
- Back-to-back reads of r1, r2, r3 with an empty FIFO → three consecutive cycles of rdValid with the correct values; rfWriteEnable=0 throughout.
- Reset mid-burst: 3 entries pending and a read in flight, assert reset → pendingCount=0, rdValid=0, wbReady=1 immediately; afterwards the register file shows none of the 3 values.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared widths and arbitration-decision encoding
// Rev 1.0
// ============================================================================
package regfile_pkg;

  localparam int IDX_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_READ      = 2'd1,
    ARB_DRAIN     = 2'd2,
    ARB_FWD_DRAIN = 2'd3
  } arb_e;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// wb_fifo : circular write-back buffer with youngest-entry index search
// Rev 1.0
// ============================================================================
module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pushValid,
  input  logic [IDX_W-1:0]         pushIndex,
  input  logic [DATA_W-1:0]        pushData,
  input  logic                     pop,
  input  logic [IDX_W-1:0]         searchIndex,
  output logic                     matchHit,
  output logic [DATA_W-1:0]        matchData,
  output logic [IDX_W-1:0]         headIndex,
  output logic [DATA_W-1:0]        headData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import regfile_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]  idxMem_q  [DEPTH];
  logic [DATA_W-1:0] dataMem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  slot;
  logic              doPush, doPop;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign doPush = pushValid && !full;
  assign doPop  = pop && !empty;
  assign count  = count_q;

  assign headIndex = idxMem_q[head_q];
  assign headData  = dataMem_q[head_q];

  always_comb begin
    head_d  = head_q + PTR_W'(doPop);
    tail_d  = tail_q + PTR_W'(doPush);
    count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (doPush) begin
      idxMem_q[tail_q]  <= pushIndex;
      dataMem_q[tail_q] <= pushData;
    end
  end

  // Walk oldest to youngest so the last hit (the youngest) wins.
  always_comb begin
    matchHit  = 1'b0;
    matchData = '0;
    slot      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (idxMem_q[slot] == searchIndex)) begin
        matchHit  = 1'b1;
        matchData = dataMem_q[slot];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_port_arbiter : shares one RF index port between reads and queued writes
// Rev 1.0
// ============================================================================
module regfile_port_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int IDX_W  = regfile_pkg::IDX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rdReq,
  input  logic [IDX_W-1:0]         rdIndex,
  output logic                     rdReady,
  output logic                     rdValid,
  output logic [DATA_W-1:0]        rdData,
  input  logic                     wbValid,
  input  logic [IDX_W-1:0]         wbIndex,
  input  logic [DATA_W-1:0]        wbData,
  output logic                     wbReady,
  output logic [IDX_W-1:0]         rfIndex,
  output logic [DATA_W-1:0]        rfValueInput,
  output logic                     rfReadEnable,
  output logic                     rfWriteEnable,
  input  logic [DATA_W-1:0]        rfValueOutput,
  output logic [$clog2(DEPTH):0]   pendingCount
);
  import regfile_pkg::*;

  arb_e              arb;
  logic              fifoFull, fifoEmpty;
  logic              matchHit;
  logic [DATA_W-1:0] matchData;
  logic [IDX_W-1:0]  headIndex;
  logic [DATA_W-1:0] headData;
  logic              wbPush;
  logic              needRfRead;

  logic              rdValid_q, rdValid_d;
  logic              rdFromRf_q, rdFromRf_d;
  logic [DATA_W-1:0] rdHeld_q, rdHeld_d;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_wb_fifo (
    .clk         (clk),
    .reset       (reset),
    .pushValid   (wbPush),
    .pushIndex   (wbIndex),
    .pushData    (wbData),
    .pop         (rfWriteEnable),
    .searchIndex (rdIndex),
    .matchHit    (matchHit),
    .matchData   (matchData),
    .headIndex   (headIndex),
    .headData    (headData),
    .full        (fifoFull),
    .empty       (fifoEmpty),
    .count       (pendingCount)
  );

  // Writes to r0 are acknowledged but never occupy a slot.
  assign wbReady    = !fifoFull;
  assign wbPush     = wbValid && !fifoFull && (wbIndex != '0);
  assign needRfRead = rdReq && (rdIndex != '0) && !matchHit;

  always_comb begin
    arb = ARB_IDLE;
    if (fifoFull) begin
      arb = ARB_DRAIN;
    end else if (needRfRead) begin
      arb = ARB_READ;
    end else if (rdReq) begin
      arb = ARB_FWD_DRAIN;
    end else if (!fifoEmpty) begin
      arb = ARB_DRAIN;
    end
  end

  assign rdReady       = rdReq && !fifoFull;
  assign rfReadEnable  = (arb == ARB_READ);
  assign rfWriteEnable = (arb == ARB_DRAIN) || ((arb == ARB_FWD_DRAIN) && !fifoEmpty);
  assign rfIndex       = rfReadEnable  ? rdIndex :
                         rfWriteEnable ? headIndex : '0;
  assign rfValueInput  = rfWriteEnable ? headData : '0;

  // Locally sourced read data is captured now; RF data arrives next cycle.
  always_comb begin
    rdValid_d  = rdReady;
    rdFromRf_d = rfReadEnable;
    rdHeld_d   = rdHeld_q;
    if (rdReady && !rfReadEnable) begin
      rdHeld_d = (rdIndex == '0) ? '0 : matchData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdValid_q  <= 1'b0;
      rdFromRf_q <= 1'b0;
      rdHeld_q   <= '0;
    end else begin
      rdValid_q  <= rdValid_d;
      rdFromRf_q <= rdFromRf_d;
      rdHeld_q   <= rdHeld_d;
    end
  end

  assign rdValid = rdValid_q;
  assign rdData  = rdFromRf_q ? rfValueOutput : rdHeld_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_port_arbiter : directed stimulus with queued expectations and a monitor
// Rev 1.0
// ============================================================================
module tb_regfile_port_arbiter;

  logic        clk;
  logic        reset;
  logic        rdReq;
  logic [4:0]  rdIndex;
  logic        rdReady;
  logic        rdValid;
  logic [31:0] rdData;
  logic        wbValid;
  logic [4:0]  wbIndex;
  logic [31:0] wbData;
  logic        wbReady;
  logic [4:0]  rfIndex;
  logic [31:0] rfValueInput;
  logic        rfReadEnable;
  logic        rfWriteEnable;
  logic [31:0] rfValueOutput;
  logic [2:0]  pendingCount;

  int total = 0;
  int bad   = 0;

  logic [31:0] rdq [$];
  logic [36:0] wrq [$];
  logic [31:0] rf_mem [regfile_pkg::NUM_REGS];

  regfile_port_arbiter #(.DEPTH(4), .DATA_W(32), .IDX_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .rdReq         (rdReq),
    .rdIndex       (rdIndex),
    .rdReady       (rdReady),
    .rdValid       (rdValid),
    .rdData        (rdData),
    .wbValid       (wbValid),
    .wbIndex       (wbIndex),
    .wbData        (wbData),
    .wbReady       (wbReady),
    .rfIndex       (rfIndex),
    .rfValueInput  (rfValueInput),
    .rfReadEnable  (rfReadEnable),
    .rfWriteEnable (rfWriteEnable),
    .rfValueOutput (rfValueOutput),
    .pendingCount  (pendingCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Register-file model: commands captured mid-cycle, applied at the edge.
  initial begin
    logic        we, re;
    logic [4:0]  ix;
    logic [31:0] d;
    for (int i = 0; i < regfile_pkg::NUM_REGS; i++) rf_mem[i] = 32'hA000_0000 + i;
    rfValueOutput = '0;
    forever begin
      @(negedge clk);
      we = rfWriteEnable; re = rfReadEnable; ix = rfIndex; d = rfValueInput;
      @(posedge clk);
      if (!reset && we) rf_mem[ix] = d;
      if (!reset && re) rfValueOutput <= rf_mem[ix];
    end
  end

  // Monitor: pops the oldest expectation whenever the DUT presents data or a write.
  initial begin
    logic [31:0] e;
    logic [36:0] w;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rdValid) begin
          if (rdq.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_unexpected: got rdValid=1 data %h expected no read", rdData);
          end else begin
            e = rdq.pop_front();
            chk("rdData", rdData, e);
          end
        end
        if (rfWriteEnable) begin
          if (wrq.size() == 0) begin
            total++; bad++;
            $display("FAIL rf_wr_unexpected: got write r%0d=%h expected none", rfIndex, rfValueInput);
          end else begin
            w = wrq.pop_front();
            chk("rf_wr_idx", {27'd0, rfIndex}, {27'd0, w[36:32]});
            chk("rf_wr_data", rfValueInput, w[31:0]);
          end
        end
        if (rfReadEnable && rfWriteEnable) begin
          total++; bad++;
          $display("FAIL rf_both_en: got re=1 we=1 expected exclusive");
        end
      end
    end
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [4:0] idx, input logic [31:0] d, input string nm);
    bit ok = 0;
    wbValid = 1'b1; wbIndex = idx; wbData = d;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (wbReady) begin ok = 1; break; end
      next();
    end
    chk({nm, "_wb_accept"}, 32'(ok), 32'd1);
    if (ok && idx != 5'd0) wrq.push_back({idx, d});
    next();
    wbValid = 1'b0;
  endtask

  task automatic rd(input logic [4:0] idx, input logic [31:0] exp, input logic expRf, input string nm);
    bit ok = 0;
    rdReq = 1'b1; rdIndex = idx;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rdReady) begin ok = 1; break; end
      next();
    end
    chk({nm, "_rd_accept"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({nm, "_rfre"}, 32'(rfReadEnable), 32'(expRf));
      rdq.push_back(exp);
    end
    next();
    rdReq = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (pendingCount == 3'd0) break;
      next();
    end
    chk({nm, "_drained"}, 32'(pendingCount), 32'd0);
    next();
  endtask

  initial begin
    logic [31:0] t5 [3];
    t5[0] = 32'h0000_1001; t5[1] = 32'h0000_2002; t5[2] = 32'h0000_3003;

    reset = 1'b1; rdReq = 1'b0; rdIndex = '0;
    wbValid = 1'b0; wbIndex = '0; wbData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pending", 32'(pendingCount), 32'd0);
    chk("rst_wbready", 32'(wbReady), 32'd1);
    chk("rst_rdvalid", 32'(rdValid), 32'd0);
    chk("rst_rddata", rdData, 32'd0);
    chk("rst_rfen", {30'd0, rfReadEnable, rfWriteEnable}, 32'd0);
    next();
    reset = 1'b0;

    // Write then read through the register file
    wb_write(5'd5, 32'hDEAD_BEEF, "t1");
    @(negedge clk);
    chk("t1_pending", 32'(pendingCount), 32'd1);
    chk("t1_drain_we", 32'(rfWriteEnable), 32'd1);
    next();
    wait_empty("t1");
    rd(5'd5, 32'hDEAD_BEEF, 1'b1, "t1");
    @(negedge clk);
    chk("t1_rdvalid", 32'(rdValid), 32'd1);
    next();

    // Forwarding from the youngest pending write
    wb_write(5'd7, 32'h11, "t2a");
    wb_write(5'd7, 32'h22, "t2b");
    rd(5'd7, 32'h22, 1'b0, "t2");
    wait_empty("t2");
    rd(5'd7, 32'h22, 1'b1, "t2rf");

    // r0 writes are dropped, r0 reads return zero
    wb_write(5'd0, 32'hFFFF_FFFF, "t3");
    @(negedge clk);
    chk("t3_pending", 32'(pendingCount), 32'd0);
    chk("t3_no_we", 32'(rfWriteEnable), 32'd0);
    next();
    rd(5'd0, 32'd0, 1'b0, "t3");

    // Fill the FIFO while a read of r9 is held
    rdReq = 1'b1; rdIndex = 5'd9;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        wbValid = 1'b1; wbIndex = 5'(10 + c); wbData = 32'hC0DE_0000 + c;
      end else begin
        wbValid = 1'b0;
      end
      @(negedge clk);
      if (c < 4) begin
        chk("t4_wbready", 32'(wbReady), 32'd1);
        wrq.push_back({wbIndex, wbData});
      end
      if (c == 4) begin
        chk("t4_full_wbready", 32'(wbReady), 32'd0);
        chk("t4_full_rdready", 32'(rdReady), 32'd0);
        chk("t4_full_we", 32'(rfWriteEnable), 32'd1);
        chk("t4_full_idx", 32'(rfIndex), 32'd10);
        chk("t4_full_pending", 32'(pendingCount), 32'd4);
      end
      if (c == 5) begin
        chk("t4_reaccept", 32'(rdReady), 32'd1);
        chk("t4_pending3", 32'(pendingCount), 32'd3);
      end
      if (rdReady) rdq.push_back(32'hA000_0009);
      next();
      if (c == 5) rdReq = 1'b0;
    end
    wait_empty("t4");
    for (int k = 0; k < 4; k++) chk("t4_rf_mem", rf_mem[10 + k], 32'hC0DE_0000 + k);
    rd(5'd12, 32'hC0DE_0002, 1'b1, "t4");

    // Back-to-back reads with an empty FIFO
    wb_write(5'd1, t5[0], "t5a");
    wb_write(5'd2, t5[1], "t5b");
    wb_write(5'd3, t5[2], "t5c");
    wait_empty("t5");
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin rdReq = 1'b1; rdIndex = 5'(c + 1); end
      else rdReq = 1'b0;
      @(negedge clk);
      chk("t5_no_we", 32'(rfWriteEnable), 32'd0);
      if (c < 3) begin
        chk("t5_rdready", 32'(rdReady), 32'd1);
        chk("t5_rfre", 32'(rfReadEnable), 32'd1);
        rdq.push_back(t5[c]);
      end
      if (c >= 1 && c <= 3) chk("t5_rdvalid", 32'(rdValid), 32'd1);
      next();
    end

    // Reset with three pending writes and a read in flight
    rdReq = 1'b1; rdIndex = 5'd9;
    for (int c = 0; c < 3; c++) begin
      wbValid = 1'b1; wbIndex = 5'(20 + c); wbData = 32'hBAD0_0000 + c;
      @(negedge clk);
      if (rdReady) rdq.push_back(32'hA000_0009);
      next();
    end
    wbValid = 1'b0; rdReq = 1'b0;
    chk("t6_pre_pending", 32'(pendingCount), 32'd3);
    chk("t6_pre_rdvalid", 32'(rdValid), 32'd1);
    reset = 1'b1;
    rdq.delete();
    wrq.delete();
    #1;
    chk("t6_pending", 32'(pendingCount), 32'd0);
    chk("t6_rdvalid", 32'(rdValid), 32'd0);
    chk("t6_wbready", 32'(wbReady), 32'd1);
    next();
    reset = 1'b0;
    repeat (6) next();
    for (int k = 0; k < 3; k++) chk("t6_rf_untouched", rf_mem[20 + k], 32'hA000_0014 + k);

    chk("end_rdq_empty", 32'(rdq.size()), 32'd0);
    chk("end_wrq_empty", 32'(wrq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
